// File: rtl/pc11_regs.sv
// PC11 paper-tape reader/punch register block (PRS/PRB/PPS/PPB) bridging the I/O page to the SD tape emulator.
// Optional macro PC11_IRQ_EN enables the IE bits and the reader/punch interrupt requests.
module pc11_regs #(
    parameter logic [15:0] BASE_ADDR = 16'o177550
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_bus_sel,
    input  logic        i_bus_we,
    input  logic [15:0] i_bus_addr,
    input  logic [15:0] i_bus_wdata,
    output logic [15:0] o_bus_rdata,
    output logic        o_bus_hit,
    output logic        o_tape_read,
    output logic        o_tape_punch,
    output logic        o_tape_clear_done,
    output logic        o_tape_flush,
    output logic [7:0]  o_tape_punch_data,
    input  logic        i_tape_read_busy,
    input  logic        i_tape_read_done,
    input  logic        i_tape_punch_ready,
    input  logic [7:0]  i_tape_read_data,
    input  logic [3:0]  i_sd_error,
    output logic        o_rdr_irq,
    output logic        o_pun_irq,
    input  logic        i_rdr_iack,
    input  logic        i_pun_iack
);

    typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_WAIT} rdr_state_t;
    typedef enum logic [1:0] {P_IDLE, P_ISSUE, P_ACK, P_DRAIN} pun_state_t;

    rdr_state_t rdr_state, rdr_next;
    pun_state_t pun_state, pun_next;

    logic       err, addr_match, wr, rd;
    logic       wr_prs, wr_pps, wr_ppb, rd_prb;
    logic       done, done_next, busy, rdy;
    logic [7:0] prb, prb_next;
    logic       read_done_d, read_rise, clear_pend;
    logic       read_req, punch_req, punch_grant, flush_op;
    logic       rdr_ie, pun_ie;
    logic [15:0] read_mux;
    logic       unused_bits;

    assign err        = (i_sd_error != 4'd0);
    assign addr_match = (i_bus_addr[15:3] == BASE_ADDR[15:3]);
    assign wr         = i_bus_sel & addr_match & i_bus_we;
    assign rd         = i_bus_sel & addr_match & ~i_bus_we;
    assign wr_prs     = wr & (i_bus_addr[2:1] == 2'd0);
    assign wr_pps     = wr & (i_bus_addr[2:1] == 2'd2);
    assign wr_ppb     = wr & (i_bus_addr[2:1] == 2'd3);
    assign rd_prb     = rd & (i_bus_addr[2:1] == 2'd1);
    assign busy       = (rdr_state != R_IDLE);
    assign rdy        = (pun_state == P_IDLE);
    assign read_rise  = i_tape_read_done & ~read_done_d;

    // Reader next-state; a DONE set later in the case overrides a same-cycle PRB read clear.
    always_comb begin
        rdr_next  = rdr_state;
        done_next = done;
        prb_next  = prb;
        read_req  = 1'b0;
        if (rd_prb)
            done_next = 1'b0;
        case (rdr_state)
            R_IDLE: begin
                if (wr_prs && i_bus_wdata[0]) begin
                    done_next = 1'b0;
                    rdr_next  = R_ISSUE;
                end
            end
            R_ISSUE: begin
                if (err) begin
                    done_next = 1'b1;
                    rdr_next  = R_IDLE;
                end else if (!i_tape_read_busy) begin
                    read_req = 1'b1;
                    if (!clear_pend)
                        rdr_next = R_WAIT;
                end
            end
            R_WAIT: begin
                if (err) begin
                    done_next = 1'b1;
                    rdr_next  = R_IDLE;
                end else if (read_rise) begin
                    prb_next  = i_tape_read_data;
                    done_next = 1'b1;
                    rdr_next  = R_IDLE;
                end
            end
            default: rdr_next = R_IDLE;
        endcase
    end

    // Punch next-state; a punch/flush request yields to the reader and to clear_done.
    always_comb begin
        pun_next  = pun_state;
        punch_req = 1'b0;
        case (pun_state)
            P_IDLE: begin
                if (wr_ppb || (wr_pps && i_bus_wdata[0]))
                    pun_next = P_ISSUE;
            end
            P_ISSUE: begin
                if (err)
                    pun_next = P_IDLE;
                else if (i_tape_punch_ready) begin
                    punch_req = 1'b1;
                    if (!read_req && !clear_pend)
                        pun_next = P_ACK;
                end
            end
            P_ACK: begin
                if (err)
                    pun_next = P_IDLE;
                else if (!i_tape_punch_ready)
                    pun_next = P_DRAIN;
            end
            P_DRAIN: begin
                if (err || i_tape_punch_ready)
                    pun_next = P_IDLE;
            end
            default: pun_next = P_IDLE;
        endcase
    end

    assign punch_grant       = punch_req & ~read_req & ~clear_pend;
    assign o_tape_clear_done = clear_pend & ~i_reset;
    assign o_tape_read       = read_req & ~clear_pend & ~i_reset;
    assign o_tape_punch      = punch_grant & ~flush_op & ~i_reset;
    assign o_tape_flush      = punch_grant & flush_op & ~i_reset;

    always_comb begin
        case (i_bus_addr[2:1])
            2'd0:    read_mux = {err, 3'b000, busy, 3'b000, done, rdr_ie, 6'b000000};
            2'd1:    read_mux = {8'h00, prb};
            2'd2:    read_mux = {err, 7'b0000000, rdy, pun_ie, 6'b000000};
            default: read_mux = 16'h0000;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rdr_state         <= R_IDLE;
            pun_state         <= P_IDLE;
            done              <= 1'b0;
            prb               <= 8'h00;
            read_done_d       <= 1'b0;
            clear_pend        <= 1'b0;
            flush_op          <= 1'b0;
            o_tape_punch_data <= 8'h00;
            o_bus_rdata       <= 16'h0000;
            o_bus_hit         <= 1'b0;
        end else begin
            rdr_state   <= rdr_next;
            pun_state   <= pun_next;
            done        <= done_next;
            prb         <= prb_next;
            read_done_d <= i_tape_read_done;
            clear_pend  <= rd_prb;
            if (pun_state == P_IDLE && wr_ppb) begin
                o_tape_punch_data <= i_bus_wdata[7:0];
                flush_op          <= 1'b0;
            end else if (pun_state == P_IDLE && wr_pps && i_bus_wdata[0]) begin
                flush_op <= 1'b1;
            end
            if (i_bus_sel) begin
                o_bus_hit   <= addr_match;
                o_bus_rdata <= (addr_match && !i_bus_we) ? read_mux : 16'h0000;
            end
        end
    end

`ifdef PC11_IRQ_EN
    logic rdr_ie_next, pun_ie_next, rdy_next, rdr_pend, pun_pend;

    assign rdr_ie_next = wr_prs ? i_bus_wdata[6] : rdr_ie;
    assign pun_ie_next = wr_pps ? i_bus_wdata[6] : pun_ie;
    assign rdy_next    = (pun_next == P_IDLE);

    // Pending sets on a rising (IE & flag) product; set takes priority over a same-cycle iack.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rdr_ie   <= 1'b0;
            pun_ie   <= 1'b0;
            rdr_pend <= 1'b0;
            pun_pend <= 1'b0;
        end else begin
            rdr_ie <= rdr_ie_next;
            pun_ie <= pun_ie_next;
            if (rdr_ie_next && done_next && !(rdr_ie && done))
                rdr_pend <= 1'b1;
            else if (i_rdr_iack || !rdr_ie_next)
                rdr_pend <= 1'b0;
            if (pun_ie_next && rdy_next && !(pun_ie && rdy))
                pun_pend <= 1'b1;
            else if (i_pun_iack || !pun_ie_next)
                pun_pend <= 1'b0;
        end
    end

    assign o_rdr_irq   = rdr_pend;
    assign o_pun_irq   = pun_pend;
    assign unused_bits = &{1'b0, i_bus_wdata[15:8], i_bus_addr[0]};
`else
    assign rdr_ie      = 1'b0;
    assign pun_ie      = 1'b0;
    assign o_rdr_irq   = 1'b0;
    assign o_pun_irq   = 1'b0;
    assign unused_bits = &{1'b0, i_bus_wdata[15:8], i_bus_addr[0], i_rdr_iack, i_pun_iack};
`endif

endmodule

// File: tb/tb_pc11_regs.sv
// Self-checking bench for pc11_regs: register table, reader/punch/flush handshakes, arbitration, error abort, IRQs, reset.
// Covers both builds of the optional PC11_IRQ_EN feature.
module tb_pc11_regs;

    localparam logic [15:0] PRS = 16'o177550;
    localparam logic [15:0] PRB = 16'o177552;
    localparam logic [15:0] PPS = 16'o177554;
    localparam logic [15:0] PPB = 16'o177556;

    logic        i_clk = 1'b0;
    logic        i_reset, i_bus_sel, i_bus_we;
    logic [15:0] i_bus_addr, i_bus_wdata, o_bus_rdata;
    logic        o_bus_hit, o_tape_read, o_tape_punch, o_tape_clear_done, o_tape_flush;
    logic [7:0]  o_tape_punch_data, i_tape_read_data;
    logic        i_tape_read_busy, i_tape_read_done, i_tape_punch_ready;
    logic [3:0]  i_sd_error;
    logic        o_rdr_irq, o_pun_irq, i_rdr_iack, i_pun_iack;

    pc11_regs dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_bus_sel(i_bus_sel), .i_bus_we(i_bus_we),
        .i_bus_addr(i_bus_addr), .i_bus_wdata(i_bus_wdata), .o_bus_rdata(o_bus_rdata),
        .o_bus_hit(o_bus_hit), .o_tape_read(o_tape_read), .o_tape_punch(o_tape_punch),
        .o_tape_clear_done(o_tape_clear_done), .o_tape_flush(o_tape_flush),
        .o_tape_punch_data(o_tape_punch_data), .i_tape_read_busy(i_tape_read_busy),
        .i_tape_read_done(i_tape_read_done), .i_tape_punch_ready(i_tape_punch_ready),
        .i_tape_read_data(i_tape_read_data), .i_sd_error(i_sd_error),
        .o_rdr_irq(o_rdr_irq), .o_pun_irq(o_pun_irq),
        .i_rdr_iack(i_rdr_iack), .i_pun_iack(i_pun_iack)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        string       name;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        chk;
        logic [15:0] rdata;
        logic        hit;
    } vec_t;

    typedef struct {
        string       name;
        logic        chk;
        logic [15:0] rdata;
        logic        hit;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[9];
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_read = 0, n_punch = 0, n_flush = 0, n_clear = 0, n_multi = 0;

    // Strobe tallies taken mid-cycle, away from the active edge.
    always @(negedge i_clk) begin
        if (o_tape_read)       n_read++;
        if (o_tape_punch)      n_punch++;
        if (o_tape_flush)      n_flush++;
        if (o_tape_clear_done) n_clear++;
        if ($countones({o_tape_read, o_tape_punch, o_tape_flush, o_tape_clear_done}) > 1) n_multi++;
    end

    function automatic vec_t mk(input string name, input logic we, input logic [15:0] addr,
                                input logic [15:0] wdata, input logic chk,
                                input logic [15:0] rdata, input logic hit);
        vec_t v;
        v.name = name; v.we = we; v.addr = addr; v.wdata = wdata;
        v.chk = chk; v.rdata = rdata; v.hit = hit;
        return v;
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input string name, input logic we, input logic [15:0] addr,
                                  input logic [15:0] wdata, input logic chk,
                                  input logic [15:0] rdata, input logic hit);
        exp_t e;
        e.name = name; e.chk = chk; e.rdata = rdata; e.hit = hit;
        i_bus_sel   = 1'b1;
        i_bus_we    = we;
        i_bus_addr  = addr;
        i_bus_wdata = wdata;
        sb.push_back(e);
        tick();
        i_bus_sel = 1'b0;
        i_bus_we  = 1'b0;
        e = sb.pop_front();
        check_output({e.name, "_hit"}, 16'(o_bus_hit), 16'(e.hit));
        if (e.chk)
            check_output(e.name, o_bus_rdata, e.rdata);
    endtask

    task automatic rd(input logic [15:0] addr, input logic [15:0] exp, input string name);
        apply_stimulus(name, 1'b0, addr, 16'h0000, 1'b1, exp, 1'b1);
    endtask

    task automatic wr(input logic [15:0] addr, input logic [15:0] data, input string name);
        apply_stimulus(name, 1'b1, addr, data, 1'b0, 16'h0000, 1'b1);
    endtask

    initial begin
        int r0, p0, f0, s0;

        vecs[0] = mk("rst_prs", 1'b0, PRS, 16'h0, 1'b1, 16'o000000, 1'b1);
        vecs[1] = mk("rst_prb", 1'b0, PRB, 16'h0, 1'b1, 16'o000000, 1'b1);
        vecs[2] = mk("rst_pps", 1'b0, PPS, 16'h0, 1'b1, 16'o000200, 1'b1);
        vecs[3] = mk("rst_ppb", 1'b0, PPB, 16'h0, 1'b1, 16'o000000, 1'b1);
        vecs[4] = mk("miss_rd", 1'b0, 16'o177560, 16'h0, 1'b0, 16'h0, 1'b0);
        vecs[5] = mk("wr_prs_ie", 1'b1, PRS, 16'o000100, 1'b0, 16'h0, 1'b1);
`ifdef PC11_IRQ_EN
        vecs[6] = mk("prs_ie", 1'b0, PRS, 16'h0, 1'b1, 16'o000100, 1'b1);
`else
        vecs[6] = mk("prs_ie", 1'b0, PRS, 16'h0, 1'b1, 16'o000000, 1'b1);
`endif
        vecs[7] = mk("wr_prs_clr", 1'b1, PRS, 16'o000000, 1'b0, 16'h0, 1'b1);
        vecs[8] = mk("prs_ie_clr", 1'b0, PRS, 16'h0, 1'b1, 16'o000000, 1'b1);

        i_reset = 1'b1; i_bus_sel = 1'b0; i_bus_we = 1'b0; i_bus_addr = 16'h0; i_bus_wdata = 16'h0;
        i_tape_read_busy = 1'b0; i_tape_read_done = 1'b0; i_tape_punch_ready = 1'b1;
        i_tape_read_data = 8'h00; i_sd_error = 4'd0; i_rdr_iack = 1'b0; i_pun_iack = 1'b0;
        repeat (3) tick();
        check_output("rst_rdata", o_bus_rdata, 16'h0000);
        check_output("rst_hit", 16'(o_bus_hit), 16'd0);
        check_output("rst_strobes", 16'({o_tape_read, o_tape_punch, o_tape_flush, o_tape_clear_done}), 16'd0);
        check_output("rst_punch_data", 16'(o_tape_punch_data), 16'h0000);
        check_output("rst_irqs", 16'({o_rdr_irq, o_pun_irq}), 16'd0);
        i_reset = 1'b0;

        for (int i = 0; i < 9; i++)
            apply_stimulus(vecs[i].name, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                           vecs[i].chk, vecs[i].rdata, vecs[i].hit);

        // Reader: GO, strobe, done edge, PRB read with clear_done.
        r0 = n_read;
        wr(PRS, 16'o000001, "go");
        check_output("go_read_strobe", 16'(o_tape_read), 16'd1);
        rd(PRS, 16'o004000, "prs_busy");
        check_output("read_strobe_one_cycle", 16'(o_tape_read), 16'd0);
        i_tape_read_data = 8'h41; i_tape_read_done = 1'b1;
        tick();
        i_tape_read_done = 1'b0;
        rd(PRS, 16'o000200, "prs_done");
        rd(PRB, 16'o000101, "prb_data");
        check_output("clear_done_pulse", 16'(o_tape_clear_done), 16'd1);
        rd(PRS, 16'o000000, "prs_done_cleared");
        check_output("read_strobe_count", 16'(n_read - r0), 16'd1);

        // Punch: strobe with data, ignored second write, ready handshake.
        p0 = n_punch;
        wr(PPB, 16'h005A, "ppb_5a");
        check_output("punch_strobe", 16'(o_tape_punch), 16'd1);
        check_output("punch_data", 16'(o_tape_punch_data), 16'h005A);
        rd(PPS, 16'o000000, "pps_busy");
        check_output("punch_one_cycle", 16'(o_tape_punch), 16'd0);
        i_tape_punch_ready = 1'b0;
        tick();
        wr(PPB, 16'h00FF, "ppb_ignored");
        check_output("punch_data_held", 16'(o_tape_punch_data), 16'h005A);
        rd(PPS, 16'o000000, "pps_still_busy");
        i_tape_punch_ready = 1'b1;
        tick();
        rd(PPS, 16'o000200, "pps_rdy");
        check_output("punch_strobe_count", 16'(n_punch - p0), 16'd1);

        // Arbitration: reader and punch become ready in the same cycle.
        i_tape_punch_ready = 1'b0;
        wr(PPB, 16'h0033, "ppb_33");
        i_tape_read_busy = 1'b1;
        wr(PRS, 16'o000001, "go_blocked");
        check_output("both_waiting", 16'({o_tape_read, o_tape_punch}), 16'd0);
        i_tape_read_busy = 1'b0; i_tape_punch_ready = 1'b1;
        #1;
        check_output("arb_reader_wins", 16'(o_tape_read), 16'd1);
        check_output("arb_punch_waits", 16'(o_tape_punch), 16'd0);
        tick();
        check_output("arb_punch_next", 16'(o_tape_punch), 16'd1);
        check_output("arb_read_done", 16'(o_tape_read), 16'd0);
        check_output("arb_punch_data", 16'(o_tape_punch_data), 16'h0033);
        tick();
        i_tape_punch_ready = 1'b0;
        tick();
        i_tape_punch_ready = 1'b1;
        tick();
        i_tape_read_data = 8'h99; i_tape_read_done = 1'b1;
        tick();
        i_tape_read_done = 1'b0;
        rd(PRB, 16'o000231, "arb_prb");
        rd(PPS, 16'o000200, "arb_pps_rdy");

        // Flush uses the punch path with the flush strobe instead.
        f0 = n_flush; p0 = n_punch;
        wr(PPS, 16'o000001, "flush");
        check_output("flush_strobe", 16'(o_tape_flush), 16'd1);
        check_output("flush_no_punch", 16'(o_tape_punch), 16'd0);
        tick();
        i_tape_punch_ready = 1'b0;
        tick();
        i_tape_punch_ready = 1'b1;
        tick();
        rd(PPS, 16'o000200, "flush_pps_rdy");
        check_output("flush_count", 16'(n_flush - f0), 16'd1);
        check_output("flush_punch_count", 16'(n_punch - p0), 16'd0);

        // Error during R_WAIT aborts with DONE set and PRB unchanged.
        r0 = n_read;
        wr(PRS, 16'o000001, "go_err");
        tick();
        i_sd_error = 4'd4;
        tick();
        rd(PRS, 16'o100200, "prs_err");
        rd(PPS, 16'o100200, "pps_err");
        rd(PRB, 16'o000231, "prb_unchanged");
        repeat (10) tick();
        check_output("err_read_count", 16'(n_read - r0), 16'd1);
        i_sd_error = 4'd0;
        rd(PRS, 16'o000000, "prs_err_clear");

`ifdef PC11_IRQ_EN
        wr(PRS, 16'o000101, "go_ie");
        check_output("rdr_irq_idle", 16'(o_rdr_irq), 16'd0);
        tick();
        i_tape_read_data = 8'h52; i_tape_read_done = 1'b1;
        tick();
        i_tape_read_done = 1'b0;
        check_output("rdr_irq_set", 16'(o_rdr_irq), 16'd1);
        rd(PRS, 16'o000300, "prs_done_ie");
        i_rdr_iack = 1'b1;
        tick();
        i_rdr_iack = 1'b0;
        check_output("rdr_irq_ack", 16'(o_rdr_irq), 16'd0);
        wr(PPS, 16'o000100, "pps_ie");
        check_output("pun_irq_ie_write", 16'(o_pun_irq), 16'd1);
        rd(PPS, 16'o000300, "pps_rdy_ie");
        wr(PPS, 16'o000000, "pps_ie_off");
        check_output("pun_irq_ie_clear", 16'(o_pun_irq), 16'd0);
        wr(PRS, 16'o000000, "prs_ie_off");
        rd(PRB, 16'o000122, "prb_irq_byte");
`else
        wr(PRS, 16'o000100, "prs_ie_noirq");
        wr(PPS, 16'o000100, "pps_ie_noirq");
        i_rdr_iack = 1'b1; i_pun_iack = 1'b1;
        tick();
        i_rdr_iack = 1'b0; i_pun_iack = 1'b0;
        check_output("irqs_tied_low", 16'({o_rdr_irq, o_pun_irq}), 16'd0);
        rd(PPS, 16'o000200, "pps_no_ie");
        rd(PRS, 16'o000000, "prs_no_ie");
`endif

        // Reset in P_ACK drops the handshake with no trailing strobe.
        wr(PPB, 16'h0077, "ppb_77");
        check_output("pre_reset_punch", 16'(o_tape_punch), 16'd1);
        tick();
        s0 = n_read + n_punch + n_flush + n_clear;
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        check_output("reset_punch_data", 16'(o_tape_punch_data), 16'h0000);
        rd(PPS, 16'o000200, "reset_pps_rdy");
        i_tape_punch_ready = 1'b0;
        repeat (3) tick();
        i_tape_punch_ready = 1'b1;
        repeat (100) tick();
        check_output("reset_no_strobes", 16'(n_read + n_punch + n_flush + n_clear - s0), 16'd0);
        check_output("strobe_exclusive", 16'(n_multi), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
